// File: rtl/rob_dispatch_alloc.sv
// Reorder buffer: multi-slot dispatch allocation, completion tracking, in-order multi-slot retire.
// Latency: dispatch->retire min 2 cycles; completion visible to retire one cycle after its edge.
// Backpressure: disp_ready drops when fewer than DISP_WIDTH slots are free; retire has no ready.
//
// Ports:
//   clk, rst_n                  core clock, async active-low reset
//   disp_valid/entry/ready/idx  dispatch request, payloads, accept, allocated indices (comb)
//   cmpl_valid/cmpl_idx         execution-complete strobe and ROB index
//   flush                       discard every in-flight entry at the next edge
//   ret_valid/entry/idx         retiring slots, oldest in slot 0
//   count/empty/full            occupancy status
module rob_dispatch_alloc #(
  parameter int DEPTH      = 16,
  parameter int DISP_WIDTH = 2,
  parameter int RET_WIDTH  = 2,
  parameter int ENTRY_W    = 64,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DISP_WIDTH-1:0]         disp_valid,
  input  logic [DISP_WIDTH*ENTRY_W-1:0] disp_entry,
  output logic                          disp_ready,
  output logic [DISP_WIDTH*IDX_W-1:0]   disp_idx,
  input  logic                          cmpl_valid,
  input  logic [IDX_W-1:0]              cmpl_idx,
  input  logic                          flush,
  output logic [RET_WIDTH-1:0]          ret_valid,
  output logic [RET_WIDTH*ENTRY_W-1:0]  ret_entry,
  output logic [RET_WIDTH*IDX_W-1:0]    ret_idx,
  output logic [IDX_W:0]                count,
  output logic                          empty,
  output logic                          full
);

  // Pointers carry one extra wrap bit above the index.
  typedef logic [IDX_W:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  ptr_t               head_q, head_d;
  ptr_t               tail_q, tail_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   done_q, done_d;
  logic [ENTRY_W-1:0] payload_q [DEPTH];

  logic [IDX_W-1:0]      disp_slot [DISP_WIDTH];
  logic [IDX_W-1:0]      ret_slot  [RET_WIDTH];
  logic [DISP_WIDTH-1:0] disp_take;
  logic                  disp_fire;
  ptr_t                  n_disp;
  ptr_t                  n_ret;
  ptr_t                  free_slots;

  assign count      = tail_q - head_q;
  assign empty      = (head_q == tail_q);
  assign full       = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign free_slots = DEPTH_P - count;
  // Occupancy only: slots freed by this cycle's retirement are not offered.
  assign disp_ready = (free_slots >= ptr_t'(DISP_WIDTH));

  // Dispatch: only the leading contiguous run of valid slots is taken.
  always_comb begin
    logic run;
    run       = 1'b1;
    n_disp    = '0;
    disp_fire = disp_ready && disp_valid[0] && !flush;
    disp_take = '0;
    disp_idx  = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      disp_slot[i]                  = tail_q[IDX_W-1:0] + IDX_W'(i);
      disp_idx[i*IDX_W +: IDX_W]    = disp_slot[i];
      run                           = run & disp_valid[i];
      disp_take[i]                  = run & disp_fire;
      n_disp                        = n_disp + ptr_t'(disp_take[i]);
    end
  end

  always_comb begin
    for (int k = 0; k < RET_WIDTH; k++) begin
      ret_slot[k] = head_q[IDX_W-1:0] + IDX_W'(k);
    end
  end

  // Retire: a slot is eligible only while every older slot from head is also retiring.
  always_comb begin
    logic run;
    run       = 1'b1;
    n_ret     = '0;
    ret_valid = '0;
    ret_entry = '0;
    ret_idx   = '0;
    for (int k = 0; k < RET_WIDTH; k++) begin
      run                              = run & valid_q[ret_slot[k]] & done_q[ret_slot[k]];
      ret_valid[k]                     = run & !flush;
      ret_idx[k*IDX_W +: IDX_W]        = ret_slot[k];
      ret_entry[k*ENTRY_W +: ENTRY_W]  = payload_q[ret_slot[k]];
      n_ret                            = n_ret + ptr_t'(ret_valid[k]);
    end
  end

  // Next state. Completion is applied before the retire clear so a redundant
  // completion of a retiring entry cannot leave a stale done bit behind.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (cmpl_valid && valid_q[cmpl_idx]) begin
        done_d[cmpl_idx] = 1'b1;
      end
      for (int k = 0; k < RET_WIDTH; k++) begin
        if (ret_valid[k]) begin
          valid_d[ret_slot[k]] = 1'b0;
          done_d[ret_slot[k]]  = 1'b0;
        end
      end
      for (int i = 0; i < DISP_WIDTH; i++) begin
        if (disp_take[i]) begin
          valid_d[disp_slot[i]] = 1'b1;
          done_d[disp_slot[i]]  = 1'b0;
        end
      end
      head_d = head_q + n_ret;
      tail_d = tail_q + n_disp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload storage carries no reset; valid bits gate everything read from it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DISP_WIDTH; i++) begin
      if (disp_take[i]) begin
        payload_q[disp_slot[i]] <= disp_entry[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

endmodule

// File: tb/tb_rob_dispatch_alloc.sv
// Testbench for rob_dispatch_alloc (DEPTH=8, 2-wide dispatch and retire).
// Directed table, hand-written corner sequences, then random traffic vs a queue model.
// Outputs are sampled at the falling edge or 1ns after inputs settle, never at the rising edge.
module tb_rob_dispatch_alloc;
  localparam int DEPTH = 8;
  localparam int DW    = 2;
  localparam int RW    = 2;
  localparam int EW    = 64;
  localparam int IW    = 3;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [DW-1:0]     disp_valid = '0;
  logic [DW*EW-1:0]  disp_entry = '0;
  logic              disp_ready;
  logic [DW*IW-1:0]  disp_idx;
  logic              cmpl_valid = 1'b0;
  logic [IW-1:0]     cmpl_idx   = '0;
  logic              flush      = 1'b0;
  logic [RW-1:0]     ret_valid;
  logic [RW*EW-1:0]  ret_entry;
  logic [RW*IW-1:0]  ret_idx;
  logic [IW:0]       count;
  logic              empty;
  logic              full;

  always #5 clk = ~clk;

  rob_dispatch_alloc #(
    .DEPTH(DEPTH), .DISP_WIDTH(DW), .RET_WIDTH(RW), .ENTRY_W(EW), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_entry(disp_entry), .disp_ready(disp_ready), .disp_idx(disp_idx),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .flush(flush),
    .ret_valid(ret_valid), .ret_entry(ret_entry), .ret_idx(ret_idx),
    .count(count), .empty(empty), .full(full)
  );

  // Non-contiguous dispatch valids are a protocol error.
  always @(posedge clk) begin
    if (rst_n) assert (disp_valid != 2'b10) else $error("protocol: non-contiguous disp_valid");
  end

  // Reference model: the ROB as an ordered list of in-flight entries, oldest first.
  typedef struct {
    int             idx;
    logic [EW-1:0]  e;
    bit             done;
  } ment_t;
  ment_t mq[$];
  int    alloc_n;   // entries allocated since reset/flush; index = alloc_n mod DEPTH
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    int            sz;
    logic [RW-1:0] rv;
    sz = mq.size();
    rv = '0;
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("disp_ready", 64'(disp_ready), 64'((DEPTH - sz) >= DW));
    for (int i = 0; i < DW; i++)
      chk("disp_idx", 64'(disp_idx[i*IW +: IW]), 64'((alloc_n + i) % DEPTH));
    if (!flush) begin
      for (int k = 0; k < RW; k++)
        if (k < sz && (k == 0 || rv[k-1] == 1'b1))
          if (mq[k].done) rv[k] = 1'b1;
    end
    chk("ret_valid", 64'(ret_valid), 64'(rv));
    for (int k = 0; k < RW; k++) begin
      if (rv[k]) begin
        chk("ret_idx", 64'(ret_idx[k*IW +: IW]), 64'(mq[k].idx));
        chk("ret_entry", ret_entry[k*EW +: EW], mq[k].e);
      end
    end
  endtask

  task automatic model_update();
    int  sz0;
    int  nret;
    bit  run;
    sz0  = mq.size();
    nret = 0;
    if (flush) begin
      mq.delete();
      alloc_n = 0;
      return;
    end
    while (nret < RW && nret < sz0 && mq[nret].done) nret++;
    if (cmpl_valid) begin
      foreach (mq[j]) if (mq[j].idx == int'(cmpl_idx)) mq[j].done = 1'b1;
    end
    repeat (nret) void'(mq.pop_front());
    if ((DEPTH - sz0) >= DW && disp_valid[0]) begin
      run = 1'b1;
      for (int i = 0; i < DW; i++) begin
        run = run && disp_valid[i];
        if (run) begin
          mq.push_back('{idx: alloc_n % DEPTH, e: disp_entry[i*EW +: EW], done: 1'b0});
          alloc_n++;
        end
      end
    end
  endtask

  task automatic apply(input logic [DW-1:0] dv, input logic cv, input logic [IW-1:0] ci, input logic fl);
    disp_valid = dv;
    cmpl_valid = cv;
    cmpl_idx   = ci;
    flush      = fl;
    disp_entry = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input logic [DW-1:0] dv, input logic cv, input logic [IW-1:0] ci, input logic fl);
    apply(dv, cv, ci, fl);
    cycle();
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    apply(2'b00, 1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_ret_valid", 64'(ret_valid), 64'd0);
    mq.delete();
    alloc_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit        rst;
    logic [1:0] dv;
    bit        cv;
    int        ci;
    bit        fl;
    int        cnt;
    bit        rdy;
    bit        fu;
    logic [1:0] rv;
    int        tail;
    int        rh;
  } vec_t;
  vec_t tbl[11];

  initial begin
    // Expected values are those seen during the row's cycle, before its edge.
    tbl[0]  = '{1, 2'b11, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0};
    tbl[1]  = '{0, 2'b11, 0, 0, 0, 2, 1, 0, 2'b00, 2, 0};
    tbl[2]  = '{0, 2'b11, 0, 0, 0, 4, 1, 0, 2'b00, 4, 0};
    tbl[3]  = '{0, 2'b11, 0, 0, 0, 6, 1, 0, 2'b00, 6, 0};
    tbl[4]  = '{0, 2'b00, 0, 0, 0, 8, 0, 1, 2'b00, 0, 0};
    tbl[5]  = '{1, 2'b11, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0};
    tbl[6]  = '{0, 2'b11, 0, 0, 0, 2, 1, 0, 2'b00, 2, 0};
    tbl[7]  = '{0, 2'b00, 1, 1, 0, 4, 1, 0, 2'b00, 4, 0};
    tbl[8]  = '{0, 2'b00, 1, 0, 0, 4, 1, 0, 2'b00, 4, 0};
    tbl[9]  = '{0, 2'b00, 0, 0, 0, 4, 1, 0, 2'b11, 4, 0};
    tbl[10] = '{0, 2'b00, 0, 0, 0, 2, 1, 0, 2'b00, 4, 2};

    alloc_n = 0;
    for (int r = 0; r < 11; r++) begin
      if (tbl[r].rst) do_reset();
      apply(tbl[r].dv, tbl[r].cv, IW'(tbl[r].ci), tbl[r].fl);
      #1;
      chk("tbl_count", 64'(count), 64'(tbl[r].cnt));
      chk("tbl_disp_ready", 64'(disp_ready), 64'(tbl[r].rdy));
      chk("tbl_full", 64'(full), 64'(tbl[r].fu));
      chk("tbl_ret_valid", 64'(ret_valid), 64'(tbl[r].rv));
      chk("tbl_disp_idx0", 64'(disp_idx[0 +: IW]), 64'(tbl[r].tail % DEPTH));
      chk("tbl_disp_idx1", 64'(disp_idx[IW +: IW]), 64'((tbl[r].tail + 1) % DEPTH));
      for (int k = 0; k < RW; k++)
        if (tbl[r].rv[k]) chk("tbl_ret_idx", 64'(ret_idx[k*IW +: IW]), 64'((tbl[r].rh + k) % DEPTH));
      cycle();
    end

    // Wrap-around: fill, retire 0..5, re-dispatch at 0,1, then retire 6,7,0,1 in order.
    do_reset();
    repeat (4) step(2'b11, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b00, 1'b1, IW'(i), 1'b0);
    step(2'b00, 1'b0, '0, 1'b0);
    chk("wrap_count_before", 64'(count), 64'd2);
    chk("wrap_disp_idx0", 64'(disp_idx[0 +: IW]), 64'd0);
    chk("wrap_disp_idx1", 64'(disp_idx[IW +: IW]), 64'd1);
    step(2'b11, 1'b0, '0, 1'b0);
    chk("wrap_count_after", 64'(count), 64'd4);
    chk("wrap_full", 64'(full), 64'd0);
    step(2'b00, 1'b1, 3'd7, 1'b0);
    step(2'b00, 1'b1, 3'd6, 1'b0);
    step(2'b00, 1'b1, 3'd1, 1'b0);
    step(2'b00, 1'b1, 3'd0, 1'b0);
    repeat (3) step(2'b00, 1'b0, '0, 1'b0);
    chk("wrap_drained", 64'(count), 64'd0);
    chk("wrap_empty", 64'(empty), 64'd1);

    // Single-slot dispatch near full.
    do_reset();
    repeat (3) step(2'b11, 1'b0, '0, 1'b0);
    apply(2'b01, 1'b0, '0, 1'b0);
    #1;
    chk("part_ready_c6", 64'(disp_ready), 64'd1);
    chk("part_idx_c6", 64'(disp_idx[0 +: IW]), 64'd6);
    cycle();
    chk("part_count7", 64'(count), 64'd7);
    apply(2'b01, 1'b0, '0, 1'b0);
    #1;
    chk("part_ready_c7", 64'(disp_ready), 64'd0);
    cycle();
    chk("part_count_still7", 64'(count), 64'd7);
    chk("part_idx_c7", 64'(disp_idx[0 +: IW]), 64'd7);

    // Flush with two retire-ready entries at head and a simultaneous dispatch.
    do_reset();
    step(2'b11, 1'b0, '0, 1'b0);
    step(2'b11, 1'b0, '0, 1'b0);
    step(2'b01, 1'b0, '0, 1'b0);
    step(2'b00, 1'b1, 3'd1, 1'b0);
    step(2'b00, 1'b1, 3'd0, 1'b0);
    apply(2'b11, 1'b0, '0, 1'b1);
    #1;
    chk("flush_ret_valid", 64'(ret_valid), 64'd0);
    chk("flush_count_in", 64'(count), 64'd5);
    cycle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_idx0", 64'(disp_idx[0 +: IW]), 64'd0);
    chk("flush_idx1", 64'(disp_idx[IW +: IW]), 64'd1);
    step(2'b00, 1'b1, 3'd3, 1'b0);
    chk("flush_late_cmpl", 64'(ret_valid), 64'd0);
    step(2'b11, 1'b0, '0, 1'b0);
    step(2'b11, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b00, 1'b1, IW'(i), 1'b0);
    repeat (2) step(2'b00, 1'b0, '0, 1'b0);
    chk("flush_idx3_not_done", 64'(count), 64'd1);
    chk("flush_idx3_no_retire", 64'(ret_valid), 64'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic [1:0]    dv;
      logic          cv;
      logic [IW-1:0] ci;
      logic          fl;
      case ($urandom_range(0, 2))
        0:       dv = 2'b00;
        1:       dv = 2'b01;
        default: dv = 2'b11;
      endcase
      cv = ($urandom_range(0, 9) < 6);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        ci = IW'(mq[$urandom_range(0, mq.size() - 1)].idx);
      else
        ci = IW'($urandom_range(0, DEPTH - 1));
      fl = ($urandom_range(0, 49) == 0);
      if (c == 400) do_reset();
      step(dv, cv, ci, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_dispatch_alloc.md
Name: rob_dispatch_alloc

Overview:
- Parametrised successor to the single-entry Dispatch→ROB hand-off.
- Accepts up to DISP_WIDTH ROB_Entry records per cycle and returns the allocated ROB index for each.
- Tracks completion per entry and retires up to RET_WIDTH completed entries in program order.
- Sits between Dispatch and Commit, owns ROB storage, and supports a full-pipeline flush.

Parameters:
- DEPTH, 16, number of ROB entries; power of two, ≥ 4.
- DISP_WIDTH, 2, dispatch slots per cycle; ≤ DEPTH.
- RET_WIDTH, 2, retire slots per cycle; ≤ DEPTH.
- ENTRY_W, 64, packed width of ROB_Entry.
- IDX_W, $clog2(DEPTH), ROB index width (derived).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- disp_valid  in  DISP_WIDTH  per-slot valid; slots contiguous from slot 0.
- disp_entry  in  DISP_WIDTH*ENTRY_W  entries, slot i at [i*ENTRY_W +: ENTRY_W].
- disp_ready  out  1  high when free slots ≥ DISP_WIDTH.
- disp_idx  out  DISP_WIDTH*IDX_W  index for slot i = (tail+i) mod DEPTH; combinational.
- cmpl_valid  in  1  execution-complete strobe.
- cmpl_idx  in  IDX_W  ROB index being completed.
- flush  in  1  discard all in-flight entries.
- ret_valid  out  RET_WIDTH  retire slot valid, oldest in slot 0.
- ret_entry  out  RET_WIDTH*ENTRY_W  retiring entries.
- ret_idx  out  RET_WIDTH*IDX_W  retiring indices.
- count  out  IDX_W+1  occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- State:
  - head and tail pointers, each IDX_W+1 bits; the MSB is the wrap bit.
  - Per-entry: valid bit, done bit, ENTRY_W payload.
  - count = tail − head, in IDX_W+1-bit arithmetic.
  - full when the indices are equal and the wrap bits differ; empty when the pointers are equal.
- Reset (async, rst_n low):
  - head = tail = 0; all valid and done bits = 0.
  - Outputs: disp_ready=1, ret_valid=0, count=0, empty=1, full=0.
  - Payload storage is not reset.
  - Reset mid-operation discards all entries.
- Dispatch:
  - Accepted on a rising edge when disp_ready && disp_valid[0].
  - n = number of leading contiguous set bits of disp_valid.
  - Entries are written at tail..tail+n−1 with valid=1, done=0; tail += n.
  - A non-contiguous disp_valid is a protocol error, flagged by a bench assertion; only the leading run is accepted.
  - disp_ready is based on current occupancy only; slots freed by same-cycle retirement are not bypassed.
- Completion:
  - On cmpl_valid, done[cmpl_idx] is set at the next edge.
  - Completion of an invalid entry is ignored.
  - Completion of an already-done entry is idempotent.
- Retirement (combinational from registered state):
  - ret_valid[k]=1 iff entries head..head+k are all valid && done.
  - Retirement stops at the first not-done entry; no skipping.
  - Retirement is unconditional (no ready): head advances by popcount(ret_valid) at the edge, and retired valid/done bits are cleared.
  - A completion arriving in the same cycle is not visible to retirement until the following cycle (one-cycle complete-to-retire latency).
- Simultaneous dispatch + retire + complete: all take effect at the same edge.
  - Index sets cannot collide: dispatch writes free slots, retire clears occupied ones.
- Wrap-around: indices are taken mod DEPTH; pointer wrap bits toggle on crossing DEPTH−1→0.
- Flush:
  - flush has priority over dispatch, completion and retirement in its cycle.
  - ret_valid forced to 0 while flush is high.
  - Next edge: head = tail = 0, all valid/done bits cleared.
  - disp_ready is still driven during flush, but no dispatch is accepted in that cycle.
- Latency: dispatch → earliest retire = 2 cycles (dispatch edge, completion edge, retire visible the cycle after).

Test Plan:
- DEPTH=8, DISP_WIDTH=2, RET_WIDTH=2 for all scenarios.
- Reset with rst_n low mid-cycle → immediately count=0, empty=1, disp_ready=1, ret_valid=00.
- Dispatch 2/cycle for 4 cycles, no completions → disp_idx {0,1},{2,3},{4,5},{6,7}; full=1, disp_ready=0 after the 4th edge; count=8.
- Entries 0–3 allocated; complete idx 1, then 0 → no retire after idx 1 (head blocked); after idx 0 completes, next cycle ret_valid=11, ret_idx {0,1}; count 4→2.
- Fill 0–7, retire 0–5, dispatch 2 → disp_idx {0,1} with wrap bit toggled; count=4; in-order retire 6,7,0,1 once all are done.
- disp_valid=01 with count=6 → disp_ready=1; one entry allocated at idx 6, count=7.
- disp_valid=01 with count=7 → disp_ready=0; nothing allocated.
- 5 entries in flight, 2 done, assert flush with disp_valid=11 → ret_valid=00 that cycle; next cycle count=0, empty=1, next disp_idx {0,1}; late cmpl_idx=3 ignored.
